fpmul_sched: RTL and testbench

Two-port round-robin scheduler that shares one fixed-latency pipelined 32-bit FP multiplier between two requesters. It accepts operand pairs over valid/ready handshakes, issues at most one pair per cycle into the multiplier, and tracks the owner of each in-flight operation with a tag delay line. It then returns each product to the requester that issued it, in issue order. It sits between the ALU operand front-end and the multiplier pipeline; operands and products pass through unmodified.

---
 rtl/fpmul_sched.sv | 120 ++++++++++++
 tb/tb_fpmul_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fpmul_sched.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_sched
// Purpose  : Round-robin scheduler sharing one fixed-latency pipelined FP
//            multiplier between two requesters. Accepts operand pairs over
//            valid/ready, issues at most one pair per cycle, tracks the owner
//            of each in-flight operation with a tag delay line and returns
//            each product to its issuer in issue order.
// Ports    : clk, reset (sync, active-low)
//            req{0,1}_valid/_ready/_a/_b : requester operand handshakes
//            mul_a, mul_b                : registered operands to multiplier
//            mul_out                     : product, MUL_LAT cycles later
//            rsp{0,1}_valid, rsp_data    : registered one-cycle responses
//            busy                        : any operation in flight
// Revision : 1.0 - initial release
// ============================================================================
module fpmul_sched #(
  parameter int MUL_LAT = 6,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_out,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic        busy
);

  localparam int              CW    = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]   c_max = CW'(MAX_OUT);
  localparam logic [CW-1:0]   c_one = CW'(1);

  // Per-requester outstanding counters and round-robin pointer
  logic [CW-1:0]    r_cnt0;
  logic [CW-1:0]    r_cnt1;
  logic             r_prio;

  // Tag delay line, stage 0..MUL_LAT; stage k holds the op issued k+1 edges ago
  logic [MUL_LAT:0] r_tag_vld;
  logic [MUL_LAT:0] r_tag_id;

  logic w_elig0, w_elig1;
  logic w_grant0, w_grant1;
  logic w_acc;
  logic w_ret, w_ret0, w_ret1;

  always_comb begin
    w_elig0  = req0_valid && (r_cnt0 < c_max);
    w_elig1  = req1_valid && (r_cnt1 < c_max);
    // Contention resolved by prio: 0 favours requester 0, 1 favours requester 1
    w_grant0 = w_elig0 && (!w_elig1 || !r_prio);
    w_grant1 = w_elig1 && (!w_elig0 ||  r_prio);
    // Grant already implies valid, so a grant is an accept at the next edge
    w_acc    = w_grant0 || w_grant1;
    w_ret    = r_tag_vld[MUL_LAT];
    w_ret0   = w_ret && !r_tag_id[MUL_LAT];
    w_ret1   = w_ret &&  r_tag_id[MUL_LAT];
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign busy       = (|r_tag_vld) || (r_cnt0 != '0) || (r_cnt1 != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tag_vld  <= '0;
      r_tag_id   <= '0;
      r_cnt0     <= '0;
      r_cnt1     <= '0;
      r_prio     <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_data   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      r_tag_vld <= {r_tag_vld[MUL_LAT-1:0], w_acc};
      r_tag_id  <= {r_tag_id[MUL_LAT-1:0],  w_grant1};

      if (w_acc) begin
        mul_a  <= w_grant1 ? req1_a : req0_a;
        mul_b  <= w_grant1 ? req1_b : req0_b;
        // Point at the requester that was not just served
        r_prio <= w_grant0;
      end

      rsp0_valid <= w_ret0;
      rsp1_valid <= w_ret1;
      if (w_ret) begin
        rsp_data <= mul_out;
      end

      // Simultaneous accept and retire on one requester leaves its count as is
      case ({w_grant0, w_ret0})
        2'b10:   r_cnt0 <= r_cnt0 + c_one;
        2'b01:   r_cnt0 <= r_cnt0 - c_one;
        default: r_cnt0 <= r_cnt0;
      endcase

      case ({w_grant1, w_ret1})
        2'b10:   r_cnt1 <= r_cnt1 + c_one;
        2'b01:   r_cnt1 <= r_cnt1 - c_one;
        default: r_cnt1 <= r_cnt1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpmul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpmul_sched
// Purpose  : Self-checking bench for fpmul_sched with an adder stub standing
//            in for the multiplier (mul_out = mul_a + mul_b, 6 cycles later)
//            and a transaction-level reference model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpmul_sched;

  localparam int c_lat = 6;
  localparam int c_max = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] mul_a, mul_b, mul_out;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data;
  logic        busy;

  fpmul_sched #(.MUL_LAT(c_lat), .MAX_OUT(c_max)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_out    (mul_out),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Multiplier stub: sum of presented operands appears c_lat cycles later
  logic [31:0] r_pipe [c_lat];
  always @(posedge clk) begin
    r_pipe[0] <= mul_a + mul_b;
    for (int i = 1; i < c_lat; i++) r_pipe[i] <= r_pipe[i-1];
  end
  assign mul_out = r_pipe[c_lat-1];

  // Reference model: in-flight operations as a FIFO with due edge numbers
  typedef struct {
    bit          id;
    logic [31:0] prod;
    int          due;
  } ent_t;

  ent_t        q[$];
  int          m_cnt [2];
  bit          m_prio;
  logic [31:0] m_mul_a, m_mul_b, m_rsp_data;
  bit          m_rsp0, m_rsp1;
  int          t_edge;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, t_edge);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_prio = 0;
    m_mul_a = '0;
    m_mul_b = '0;
    m_rsp_data = '0;
    m_rsp0 = 0;
    m_rsp1 = 0;
  endtask

  // One clock cycle: drive, check grants, advance, check registered outputs
  task automatic step(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                      input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                      input bit rst_n);
    bit e0, e1, g0, g1;
    ent_t e;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    reset = rst_n;
    #1;
    e0 = v0 && (m_cnt[0] < c_max);
    e1 = v1 && (m_cnt[1] < c_max);
    if (e0 && e1) begin
      g0 = (m_prio == 0);
      g1 = (m_prio == 1);
    end else begin
      g0 = e0;
      g1 = e1;
    end
    if (rst_n) begin
      chk("ready0", {31'b0, req0_ready}, {31'b0, g0});
      chk("ready1", {31'b0, req1_ready}, {31'b0, g1});
    end
    @(posedge clk);
    t_edge++;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rsp0 = 0;
      m_rsp1 = 0;
      if (q.size() > 0 && q[0].due == t_edge) begin
        e = q.pop_front();
        if (e.id) m_rsp1 = 1; else m_rsp0 = 1;
        m_rsp_data = e.prod;
        m_cnt[e.id]--;
      end
      if (g0 || g1) begin
        e.id   = g1;
        e.prod = g1 ? (a1 + b1) : (a0 + b0);
        e.due  = t_edge + c_lat + 1;
        q.push_back(e);
        m_cnt[e.id]++;
        m_mul_a = g1 ? a1 : a0;
        m_mul_b = g1 ? b1 : b0;
        m_prio  = g0;
      end
    end
    #1;
    chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, m_rsp0});
    chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, m_rsp1});
    chk("rsp_excl",   {31'b0, rsp0_valid & rsp1_valid}, 32'h0);
    chk("rsp_data",   rsp_data, m_rsp_data);
    chk("mul_a",      mul_a, m_mul_a);
    chk("mul_b",      mul_b, m_mul_b);
    chk("busy",       {31'b0, busy}, {31'b0, q.size() != 0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    t_edge   = 0;
    model_reset();
    reset = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    // Reset held with both requesters valid; nothing may be accepted
    for (int i = 0; i < 3; i++) step(1, 32'h1, 32'h2, 1, 32'h3, 32'h4, 0);
    // First cycle after release: both valid, grant must go to requester 0
    step(1, 32'h11, 32'h22, 1, 32'h33, 32'h44, 1);
    idle(12);

    // Single request: 0x10 + 0x20 returns 0x30 on port 0
    step(1, 32'h10, 32'h20, 0, '0, '0, 1);
    idle(10);

    // Contention: alternating grants, products return in issue order
    for (int i = 0; i < 40; i++)
      step(1, 32'h1000 + i, 32'h7, 1, 32'h2000 + i, 32'h9, 1);
    idle(12);

    // Outstanding limit on a single requester
    for (int i = 0; i < 30; i++)
      step(1, 32'h100 * i, 32'h5, 0, '0, '0, 1);
    idle(12);

    // Reset with three operations in flight; their products must be dropped
    for (int i = 0; i < 3; i++)
      step(1, 32'hA0 + i, 32'h1, 0, '0, '0, 1);
    step(0, '0, '0, 0, '0, '0, 0);
    idle(12);

    // Random traffic
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom, $urandom, 1);
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
